// File: rtl/mac_div_pkg.sv
// Shared definitions for the sequential 16-by-8 restoring divider.
package mac_div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int ITER_W     = 4;
  // One extra bit on the partial remainder so the shifted value never overflows.
  localparam int PR_W       = DIVISOR_W + 1;

  // Quotient reported when the divisor is zero.
  localparam logic [DIVIDEND_W-1:0] DZ_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mac_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, subtract the divisor if it fits, and report the quotient bit.
module mac_div_step
  import mac_div_pkg::*;
(
  input  logic [PR_W-1:0]      pr,
  input  logic                 next_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [PR_W-1:0]      pr_next,
  output logic                 q_bit
);

  logic [PR_W-1:0] shifted;
  // The incoming remainder is always below the divisor, so its top bit is zero.
  logic            unused_pr_msb;

  assign unused_pr_msb = pr[PR_W-1];

  // Trial subtraction; keep the shifted value when the divisor does not fit.
  always_comb begin
    shifted = {pr[PR_W-2:0], next_bit};
    pr_next = shifted;
    q_bit   = 1'b0;
    if (shifted >= {1'b0, divisor}) begin
      pr_next = shifted - {1'b0, divisor};
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/mac_div16by8.sv
// Sequential 16-bit by 8-bit restoring divider, 16 iterations per result.
// Optional two's-complement operands: define MAC_DIV_SIGNED_EN.
//
// Handshake: start is sampled only in IDLE; on that edge the operands are
// captured and may change afterwards. busy is high for the 16 RUN cycles,
// done pulses for one cycle when results land, and quotient/remainder/
// div_by_zero hold their values until the next done. start while busy or
// done is dropped, not queued. A zero divisor skips RUN and completes at once.
module mac_div16by8
  import mac_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output state_e                dbg_state
);

  state_e                state;
  logic [DIVIDEND_W-1:0] dvd_sh;
  logic [DIVISOR_W-1:0]  dvs;
  logic [PR_W-1:0]       pr;
  logic [DIVIDEND_W-1:0] q_sh;
  logic [ITER_W-1:0]     cnt;

  logic [PR_W-1:0]       pr_nx;
  logic                  q_bit;
  logic [DIVIDEND_W-1:0] q_final;
  logic [DIVISOR_W-1:0]  r_final;
  logic [DIVIDEND_W-1:0] dvd_mag;
  logic [DIVISOR_W-1:0]  dvs_mag;
  logic [DIVIDEND_W-1:0] res_q;
  logic [DIVISOR_W-1:0]  res_r;

  assign dbg_state = state;

  mac_div_step u_step (
    .pr       (pr),
    .next_bit (dvd_sh[DIVIDEND_W-1]),
    .divisor  (dvs),
    .pr_next  (pr_nx),
    .q_bit    (q_bit)
  );

  // Quotient and remainder as they stand after the current iteration.
  assign q_final = {q_sh[DIVIDEND_W-2:0], q_bit};
  assign r_final = pr_nx[DIVISOR_W-1:0];

`ifdef MAC_DIV_SIGNED_EN
  logic q_neg;
  logic r_neg;

  // Magnitudes go into the unsigned core; signs are reapplied at the end.
  // -32768 maps to 16'h8000, which the unsigned core handles directly.
  always_comb begin
    dvd_mag = dividend[DIVIDEND_W-1] ? (~dividend + 1'b1) : dividend;
    dvs_mag = divisor[DIVISOR_W-1]   ? (~divisor + 1'b1)  : divisor;
    res_q   = q_neg ? (~q_final + 1'b1) : q_final;
    res_r   = r_neg ? (~r_final + 1'b1) : r_final;
  end

  // Result signs: quotient truncates toward zero, remainder follows the dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (state == IDLE && start) begin
      q_neg <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
      r_neg <= dividend[DIVIDEND_W-1];
    end
  end
`else
  // Unsigned operation: operands and results pass straight through.
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    res_q   = q_final;
    res_r   = r_final;
  end
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd_sh      <= '0;
      dvs         <= '0;
      pr          <= '0;
      q_sh        <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              quotient    <= DZ_QUOTIENT;
              remainder   <= dividend[DIVISOR_W-1:0];
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              dvd_sh <= dvd_mag;
              dvs    <= dvs_mag;
              pr     <= '0;
              q_sh   <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          pr     <= pr_nx;
          dvd_sh <= {dvd_sh[DIVIDEND_W-2:0], 1'b0};
          q_sh   <= q_final;
          cnt    <= cnt + 1'b1;
          if (cnt == {ITER_W{1'b1}}) begin
            quotient    <= res_q;
            remainder   <= res_r;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
